// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into one AXI4-Lite read or write.
// Latency: command accept to RSP_VALID is 3 cycles minimum with an always-ready slave (read, or write with AW/W together).
// Backpressure: CMD_READY only in IDLE; every AXI VALID and RSP_VALID is held with a stable payload until its handshake.
module axi_4_lite_mst #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESET,
    // command side
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [DATA_WIDTH-1:0] CMD_WDATA,
    input  logic [STRB_WIDTH-1:0] CMD_WSTRB,
    // response side
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_WRITE,
    output logic [DATA_WIDTH-1:0] RSP_RDATA,
    output logic [1:0]            RSP_RESP,
    // write address channel
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]            M_AXI_AWPROT,
    // write data channel
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
    // write response channel
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,
    // read address channel
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,
    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]            M_AXI_ARPROT,
    // read data channel
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY,
    input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP
);

    localparam logic [2:0] S_IDLE         = 3'd0;
    localparam logic [2:0] S_WR_ADDR_DATA = 3'd1;
    localparam logic [2:0] S_WR_RESP      = 3'd2;
    localparam logic [2:0] S_RD_ADDR      = 3'd3;
    localparam logic [2:0] S_RD_DATA      = 3'd4;
    localparam logic [2:0] S_RESP         = 3'd5;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  write_q;
    logic                  awvalid_q;
    logic                  wvalid_q;
    logic                  arvalid_q;
    logic                  aw_done;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [1:0]            rsp_resp_q;

    // A channel counts as finished if it completed earlier or is completing on this edge,
    // so AW and W may finish in either order or together.
    logic aw_fin;
    logic w_fin;
    assign aw_fin = aw_done || (awvalid_q && M_AXI_AWREADY);
    assign w_fin  = w_done  || (wvalid_q  && M_AXI_WREADY);

    // Handshake-facing outputs derived from the state register and the latched command.
    assign CMD_READY     = (state == S_IDLE);
    assign RSP_VALID     = (state == S_RESP);
    assign M_AXI_BREADY  = (state == S_WR_RESP);
    assign M_AXI_RREADY  = (state == S_RD_DATA);
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_ARPROT  = 3'b000;
    assign RSP_WRITE     = write_q;
    assign RSP_RDATA     = rsp_rdata_q;
    assign RSP_RESP      = rsp_resp_q;

    // Transaction sequencer: latch the command, drive each AXI channel, capture the response.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            write_q     <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (CMD_VALID) begin
                        addr_q  <= CMD_ADDR;
                        wdata_q <= CMD_WDATA;
                        wstrb_q <= CMD_WSTRB;
                        write_q <= CMD_WRITE;
                        if (CMD_WRITE) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            aw_done   <= 1'b0;
                            w_done    <= 1'b0;
                            state     <= S_WR_ADDR_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= S_RD_ADDR;
                        end
                    end
                end
                S_WR_ADDR_DATA: begin
                    if (awvalid_q && M_AXI_AWREADY) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (wvalid_q && M_AXI_WREADY) begin
                        wvalid_q <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        state <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (M_AXI_BVALID) begin
                        rsp_resp_q  <= M_AXI_BRESP;
                        rsp_rdata_q <= '0;
                        state       <= S_RESP;
                    end
                end
                S_RD_ADDR: begin
                    if (M_AXI_ARREADY) begin
                        arvalid_q <= 1'b0;
                        state     <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (M_AXI_RVALID) begin
                        rsp_rdata_q <= M_AXI_RDATA;
                        rsp_resp_q  <= M_AXI_RRESP;
                        state       <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (RSP_READY) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
